// File: rtl/sa_cache_tag.sv
// sa_cache_tag -- N-way set-associative tag store with flush sequencer.
//
// Holds tag/valid/dirty per {set, way}, answers a registered hit/miss
// lookup (one-cycle latency) and nominates a replacement victim per set.
// A flush walks every set, one per cycle, clearing valid, dirty and
// replacement state (tags are left untouched).
//
// Replacement policy selected at build time by macro SA_CACHE_TAG_PLRU_EN:
//   defined   : per-set tree pseudo-LRU (WAYS-1 node bits per set)
//   undefined : one global round-robin pointer
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   lk_valid/index/tag    lookup request; lk_ready high when accepted
//   rsp_*                 lookup result, valid for one cycle after accept
//   upd_*                 write tag/valid/dirty of one way
//   flush_req             start invalidate-all
//   flush_busy/done       flush in progress / one-cycle completion pulse
module sa_cache_tag #(
  parameter int WAYS      = 4,
  parameter int SETS      = 64,
  parameter int SET_WIDTH = $clog2(SETS),
  parameter int WAY_WIDTH = $clog2(WAYS),
  parameter int TAG_WIDTH = 32 - SET_WIDTH - 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lk_valid,
  input  logic [SET_WIDTH-1:0] lk_index,
  input  logic [TAG_WIDTH-1:0] lk_tag,
  output logic                 lk_ready,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [WAY_WIDTH-1:0] rsp_way,
  output logic                 rsp_dirty,
  output logic [WAY_WIDTH-1:0] rsp_victim_way,
  output logic                 rsp_victim_valid,
  output logic                 rsp_victim_dirty,
  output logic [TAG_WIDTH-1:0] rsp_victim_tag,
  input  logic                 upd_valid,
  input  logic [SET_WIDTH-1:0] upd_index,
  input  logic [WAY_WIDTH-1:0] upd_way,
  input  logic [TAG_WIDTH-1:0] upd_tag,
  input  logic                 upd_vbit,
  input  logic                 upd_dbit,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [SET_WIDTH-1:0] cnt_q, cnt_d;

  logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      valid_d [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];
  logic [WAYS-1:0]      dirty_d [SETS];

`ifdef SA_CACHE_TAG_PLRU_EN
  logic [WAYS-2:0]      plru_q  [SETS];
  logic [WAYS-2:0]      plru_d  [SETS];

  // Follow node bits from the root; a 1 steers toward the upper subtree.
  // Nodes are heap-ordered: children of n are 2n+1 and 2n+2.
  function automatic logic [WAY_WIDTH-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_WIDTH-1:0] way;
    logic                 b;
    int                   n;
    way = '0;
    n   = 0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      b   = bits[WAY_WIDTH'(n)];
      way = (way << 1) | WAY_WIDTH'(b);
      n   = 2 * n + 1 + int'(b);
    end
    return way;
  endfunction

  // Point every node on the touched way's path away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_WIDTH-1:0] way);
    logic [WAYS-2:0]      r;
    logic [WAY_WIDTH-1:0] rem;
    logic                 b;
    int                   n;
    r   = bits;
    rem = way;
    n   = 0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      b   = rem[WAY_WIDTH-1];
      rem = rem << 1;
      r[WAY_WIDTH'(n)] = ~b;
      n   = 2 * n + 1 + int'(b);
    end
    return r;
  endfunction
`else
  logic [WAY_WIDTH-1:0] rr_q, rr_d;
`endif

  // Registered lookup response.
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic [WAY_WIDTH-1:0] rsp_way_q, rsp_way_d;
  logic                 rsp_dirty_q, rsp_dirty_d;
  logic [WAY_WIDTH-1:0] vic_way_q, vic_way_d;
  logic                 vic_valid_q, vic_valid_d;
  logic                 vic_dirty_q, vic_dirty_d;
  logic [TAG_WIDTH-1:0] vic_tag_q, vic_tag_d;

  logic                 lk_fire, upd_fire;
  logic [WAYS-1:0]      lk_vrow, lk_drow, match;
  logic                 hit, any_inv;
  logic [WAY_WIDTH-1:0] hit_way, inv_way, pol_way, vic_way;

  assign lk_fire  = lk_valid && (state_q == ST_IDLE);
  assign upd_fire = upd_valid && (state_q == ST_IDLE);
  assign lk_vrow  = valid_q[lk_index];
  assign lk_drow  = dirty_q[lk_index];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_match
      assign match[gi] = lk_vrow[gi] && (tag_q[lk_index][gi] == lk_tag);
    end
  endgenerate

`ifdef SA_CACHE_TAG_PLRU_EN
  assign pol_way = plru_victim(plru_q[lk_index]);
`else
  assign pol_way = rr_q;
`endif

  // Priority encoders: scan downward so the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        hit     = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
      if (!lk_vrow[w]) begin
        any_inv = 1'b1;
        inv_way = WAY_WIDTH'(w);
      end
    end
    vic_way = any_inv ? inv_way : pol_way;
  end

  always_comb begin
    rsp_valid_d = lk_fire;
    rsp_hit_d   = rsp_hit_q;
    rsp_way_d   = rsp_way_q;
    rsp_dirty_d = rsp_dirty_q;
    vic_way_d   = vic_way_q;
    vic_valid_d = vic_valid_q;
    vic_dirty_d = vic_dirty_q;
    vic_tag_d   = vic_tag_q;
    if (lk_fire) begin
      rsp_hit_d   = hit;
      rsp_way_d   = hit_way;
      rsp_dirty_d = hit && lk_drow[hit_way];
      vic_way_d   = vic_way;
      vic_valid_d = lk_vrow[vic_way];
      vic_dirty_d = lk_drow[vic_way];
      vic_tag_d   = tag_q[lk_index][vic_way];
    end
  end

  // Flush FSM plus valid/dirty/replacement next-state. The lookup touch is
  // applied before the update touch so a same-set update wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
`ifdef SA_CACHE_TAG_PLRU_EN
    plru_d  = plru_q;
    if (lk_fire && hit)
      plru_d[lk_index] = plru_touch(plru_d[lk_index], hit_way);
    if (upd_fire && upd_vbit)
      plru_d[upd_index] = plru_touch(plru_d[upd_index], upd_way);
`else
    rr_d    = rr_q;
    if (lk_fire && !hit && !any_inv)
      rr_d = rr_q + 1'b1;
`endif
    if (upd_fire) begin
      valid_d[upd_index][upd_way] = upd_vbit;
      dirty_d[upd_index][upd_way] = upd_dbit;
    end
    case (state_q)
      ST_IDLE: if (flush_req) state_d = ST_WALK;
      ST_WALK: begin
        valid_d[cnt_q] = '0;
        dirty_d[cnt_q] = '0;
`ifdef SA_CACHE_TAG_PLRU_EN
        plru_d[cnt_q]  = '0;
`endif
        if (cnt_q == SET_WIDTH'(SETS - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
`ifdef SA_CACHE_TAG_PLRU_EN
        plru_q[s]  <= '0;
`endif
      end
`ifndef SA_CACHE_TAG_PLRU_EN
      rr_q        <= '0;
`endif
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_way_q   <= '0;
      rsp_dirty_q <= 1'b0;
      vic_way_q   <= '0;
      vic_valid_q <= 1'b0;
      vic_dirty_q <= 1'b0;
      vic_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
`ifdef SA_CACHE_TAG_PLRU_EN
      plru_q      <= plru_d;
`else
      rr_q        <= rr_d;
`endif
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_way_q   <= rsp_way_d;
      rsp_dirty_q <= rsp_dirty_d;
      vic_way_q   <= vic_way_d;
      vic_valid_q <= vic_valid_d;
      vic_dirty_q <= vic_dirty_d;
      vic_tag_q   <= vic_tag_d;
    end
  end

  // Tag contents carry no reset; they only matter once valid is set.
  always_ff @(posedge clk) begin
    if (upd_fire) tag_q[upd_index][upd_way] <= upd_tag;
  end

  assign lk_ready         = (state_q == ST_IDLE);
  assign flush_busy       = (state_q == ST_WALK);
  assign flush_done       = (state_q == ST_DONE);
  assign rsp_valid        = rsp_valid_q;
  assign rsp_hit          = rsp_hit_q;
  assign rsp_way          = rsp_way_q;
  assign rsp_dirty        = rsp_dirty_q;
  assign rsp_victim_way   = vic_way_q;
  assign rsp_victim_valid = vic_valid_q;
  assign rsp_victim_dirty = vic_dirty_q;
  assign rsp_victim_tag   = vic_tag_q;

endmodule

// File: tb/tb_sa_cache_tag.sv
// tb_sa_cache_tag -- self-checking bench for sa_cache_tag (WAYS=4, SETS=8,
// TAG_WIDTH=8). A per-set behavioural model (tag/valid/dirty tables, a
// 4-way pseudo-LRU expressed as root/left/right pointers or a global
// round-robin counter, and a flush age counter) predicts every response.
module tb_sa_cache_tag;
  localparam int WAYS = 4;
  localparam int SETS = 8;
  localparam int SW   = 3;
  localparam int WW   = 2;
  localparam int TW   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lk_valid;
  logic [SW-1:0] lk_index;
  logic [TW-1:0] lk_tag;
  logic          lk_ready;
  logic          rsp_valid, rsp_hit, rsp_dirty;
  logic [WW-1:0] rsp_way, rsp_victim_way;
  logic          rsp_victim_valid, rsp_victim_dirty;
  logic [TW-1:0] rsp_victim_tag;
  logic          upd_valid;
  logic [SW-1:0] upd_index;
  logic [WW-1:0] upd_way;
  logic [TW-1:0] upd_tag;
  logic          upd_vbit, upd_dbit;
  logic          flush_req, flush_busy, flush_done;

  always #5 clk = ~clk;

  sa_cache_tag #(.WAYS(WAYS), .SETS(SETS), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_tag(lk_tag), .lk_ready(lk_ready),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_dirty(rsp_dirty),
    .rsp_victim_way(rsp_victim_way), .rsp_victim_valid(rsp_victim_valid),
    .rsp_victim_dirty(rsp_victim_dirty), .rsp_victim_tag(rsp_victim_tag),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way), .upd_tag(upd_tag),
    .upd_vbit(upd_vbit), .upd_dbit(upd_dbit),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  int m_tag   [SETS][WAYS];
  bit m_v     [SETS][WAYS];
  bit m_d     [SETS][WAYS];
  bit m_root  [SETS];   // 1: victim in ways 2..3
  bit m_left  [SETS];   // 1: victim way 1 (else 0)
  bit m_right [SETS];   // 1: victim way 3 (else 2)
  int m_rr;
  int m_age;            // edges since flush accepted; 0 = idle

  function void model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin m_v[s][w] = 0; m_d[s][w] = 0; end
      m_root[s] = 0; m_left[s] = 0; m_right[s] = 0;
    end
    m_rr  = 0;
    m_age = 0;
  endfunction

  function void model_touch(int s, int w);
    m_root[s] = (w < 2);
    if (w < 2) m_left[s] = (w == 0);
    else       m_right[s] = (w == 2);
  endfunction

  function int model_policy(int s);
`ifdef SA_CACHE_TAG_PLRU_EN
    return m_root[s] ? (m_right[s] ? 3 : 2) : (m_left[s] ? 1 : 0);
`else
    return m_rr;
`endif
  endfunction

  // One clock: drive inputs, predict, clock, update model, compare.
  task automatic cycle(input bit lv, input int li, input int lt,
                       input bit uv, input int ui, input int uw, input int ut,
                       input bit ub, input bit ud, input bit fr);
    bit ready, acc, e_hit, e_dirty, e_vv, e_vd;
    int e_way, e_vw, e_vt, inv;
    lk_valid = lv; lk_index = li[SW-1:0]; lk_tag = lt[TW-1:0];
    upd_valid = uv; upd_index = ui[SW-1:0]; upd_way = uw[WW-1:0]; upd_tag = ut[TW-1:0];
    upd_vbit = ub; upd_dbit = ud; flush_req = fr;
    ready = (m_age == 0);
    acc   = lv && ready;
    e_hit = 0; e_way = 0; inv = -1;
    for (int w = 0; w < WAYS; w++)
      if (!e_hit && m_v[li][w] && m_tag[li][w] == lt) begin e_hit = 1; e_way = w; end
    for (int w = WAYS - 1; w >= 0; w--) if (!m_v[li][w]) inv = w;
    e_dirty = e_hit && m_d[li][e_way];
    e_vw    = (inv >= 0) ? inv : model_policy(li);
    e_vv    = m_v[li][e_vw];
    e_vd    = m_d[li][e_vw];
    e_vt    = m_tag[li][e_vw];
    @(posedge clk);
    if (acc) begin
      if (e_hit) model_touch(li, e_way);
      else if (inv < 0) m_rr = (m_rr + 1) % WAYS;
    end
    if (uv && ready) begin
      m_tag[ui][uw] = ut; m_v[ui][uw] = ub; m_d[ui][uw] = ud;
`ifdef SA_CACHE_TAG_PLRU_EN
      if (ub) model_touch(ui, uw);
`endif
    end
    if (m_age >= 1 && m_age <= SETS) begin
      for (int w = 0; w < WAYS; w++) begin m_v[m_age-1][w] = 0; m_d[m_age-1][w] = 0; end
      m_root[m_age-1] = 0; m_left[m_age-1] = 0; m_right[m_age-1] = 0;
    end
    if (m_age == 0)             m_age = fr ? 1 : 0;
    else if (m_age == SETS + 1) m_age = 0;
    else                        m_age++;
    #1;
    check_eq("rsp_valid", rsp_valid, acc);
    if (acc) begin
      $display("lk set=%0d tag=%02h hit=%0d way=%0d dirty=%0d victim=%0d vvalid=%0d",
               li, lt, rsp_hit, rsp_way, rsp_dirty, rsp_victim_way, rsp_victim_valid);
      check_eq("rsp_hit", rsp_hit, e_hit);
      check_eq("rsp_way", rsp_way, e_way);
      check_eq("rsp_dirty", rsp_dirty, e_dirty);
      check_eq("victim_way", rsp_victim_way, e_vw);
      check_eq("victim_valid", rsp_victim_valid, e_vv);
      check_eq("victim_dirty", rsp_victim_dirty, e_vd);
      if (e_vv) check_eq("victim_tag", rsp_victim_tag, e_vt);
    end
    check_eq("flush_busy", flush_busy, (m_age >= 1 && m_age <= SETS));
    check_eq("flush_done", flush_done, (m_age == SETS + 1));
    check_eq("lk_ready", lk_ready, (m_age == 0));
  endtask

  task automatic lookup(input int s, input int t);
    cycle(1, s, t, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic update(input int s, input int w, input int t, input bit v, input bit d);
    cycle(0, 0, 0, 1, s, w, t, v, d, 0);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int busy_cnt, done_at;
    rst_n = 1'b0;
    lk_valid = 0; lk_index = '0; lk_tag = '0;
    upd_valid = 0; upd_index = '0; upd_way = '0; upd_tag = '0;
    upd_vbit = 0; upd_dbit = 0; flush_req = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_hit", rsp_hit, 0);
    check_eq("rst_victim_way", rsp_victim_way, 0);
    check_eq("rst_lk_ready", lk_ready, 1);
    check_eq("rst_flush_busy", flush_busy, 0);
    check_eq("rst_flush_done", flush_done, 0);
    @(negedge clk) rst_n = 1'b1;

    // Cold miss
    lookup(3, 'h5A);
    check_eq("t1_hit", rsp_hit, 0);
    check_eq("t1_victim", rsp_victim_way, 0);
    check_eq("t1_vvalid", rsp_victim_valid, 0);

    // Update then hit
    update(3, 2, 'h5A, 1, 1);
    lookup(3, 'h5A);
    check_eq("t2_hit", rsp_hit, 1);
    check_eq("t2_way", rsp_way, 2);
    check_eq("t2_dirty", rsp_dirty, 1);

    // Replacement in a full set
    for (int w = 0; w < WAYS; w++) update(5, w, 'h10 + w, 1, 0);
    lookup(5, 'h99);
    check_eq("t3_victim0", rsp_victim_way, 0);
    check_eq("t3_vtag0", rsp_victim_tag, 'h10);
    lookup(5, 'h10);
    check_eq("t3_hit", rsp_hit, 1);
    lookup(5, 'h99);
`ifdef SA_CACHE_TAG_PLRU_EN
    check_eq("t3_victim1", rsp_victim_way, 2);
`else
    check_eq("t3_victim1", rsp_victim_way, 1);
`endif

    // Same-edge lookup and invalidating update: lookup sees old contents
    cycle(1, 3, 'h5A, 1, 3, 2, 'h5A, 0, 0, 0);
    check_eq("t4_old_hit", rsp_hit, 1);
    lookup(3, 'h5A);
    check_eq("t4_new_hit", rsp_hit, 0);

    // Fill all sets, flush with updates and lookups attempted meanwhile
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) update(s, w, s * 16 + w, 1, w[0]);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    busy_cnt = flush_busy ? 1 : 0;
    done_at  = 0;
    for (int i = 2; i <= 10; i++) begin
      cycle(1, i % SETS, 'hEE, 1, i % SETS, 1, 'hEE, 1, 1, 0);
      if (flush_busy) busy_cnt++;
      if (flush_done) done_at = i;
    end
    check_eq("t5_busy_cycles", busy_cnt, 8);
    check_eq("t5_done_cycle", done_at, 9);
    for (int s = 0; s < SETS; s++) lookup(s, s * 16 + 1);
    check_eq("t5_post_flush_hit", rsp_hit, 0);
    lookup(1, 'hEE);
    check_eq("t5_upd_ignored", rsp_hit, 0);

    // Refill, start a flush, reset while set 3 is being cleared
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) update(s, w, s * 16 + w + 8, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("t6_busy_in_rst", flush_busy, 0);
    check_eq("t6_ready_in_rst", lk_ready, 1);
    check_eq("t6_done_in_rst", flush_done, 0);
    @(negedge clk) rst_n = 1'b1;
    lookup(6, 6 * 16 + 8);
    check_eq("t6_set6_miss", rsp_hit, 0);

    // Randomized traffic over a small tag pool to provoke hits and evictions
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, SETS - 1), $urandom_range(0, 5),
            $urandom_range(0, 2) == 0, $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1),
            $urandom_range(0, 5), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 79) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
